// File: rtl/quad_step_decoder_pkg.sv
// Shared types and Gray-code helpers for the quadrature step decoder.
// step_dir turns a pair of filtered {A,B} codes into {up, down, illegal}.
package qdec_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } qdec_state_t;

    localparam logic [1:0] GRAY_0 = 2'b00;
    localparam logic [1:0] GRAY_1 = 2'b01;
    localparam logic [1:0] GRAY_2 = 2'b11;
    localparam logic [1:0] GRAY_3 = 2'b10;

    function automatic logic [1:0] gray_pos(input logic [1:0] code);
        case (code)
            GRAY_0:  return 2'd0;
            GRAY_1:  return 2'd1;
            GRAY_2:  return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Position difference modulo 4: +1 is forward, -1 is reverse, 2 is a double-phase jump.
    function automatic logic [2:0] step_dir(input logic [1:0] prev, input logic [1:0] curr);
        logic [1:0] delta;
        delta = gray_pos(curr) - gray_pos(prev);
        case (delta)
            2'd1:    return 3'b100;
            2'd3:    return 3'b010;
            2'd2:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/quad_step_decoder_phase_filter.sv
// Synchroniser plus glitch filter for one encoder phase.
// The filtered output only follows the synchronised input after FILT_LEN consecutive mismatching cycles.
module phase_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic load,
    output logic filt
);

    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   sync_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Filter stage: load bypasses the debounce so INIT can adopt the resting position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            filt <= sync_s;
            cnt  <= '0;
        end else if (sync_s != filt) begin
            if (cnt == CNT_LAST) begin
                filt <= sync_s;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature front-end: filtered A/B phases decoded into one-cycle up/down strobes,
// with a sticky error flag and saturating counter for double-phase jumps.
module quad_step_decoder
    import qdec_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clr_err,
    output logic             up,
    output logic             down,
    output logic             dir,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    localparam int INIT_LEN = SYNC_STAGES + FILT_LEN;
    localparam int INIT_W   = $clog2(INIT_LEN + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_LEN - 1);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    qdec_state_t       state, state_nxt;
    logic [INIT_W-1:0] init_cnt;
    logic              load, run_en;
    logic              fa, fb;
    logic [1:0]        ab_p0, ab_p1;
    logic              step_up, step_down, step_ill;
    logic              up_p0, down_p0, ill_p0;

    phase_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
        .clk  (clk),
        .rst  (rst),
        .raw  (enc_a),
        .load (load),
        .filt (fa)
    );

    phase_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
        .clk  (clk),
        .rst  (rst),
        .raw  (enc_b),
        .load (load),
        .filt (fb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                init_cnt <= init_cnt + INIT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        run_en    = 1'b0;
        case (state)
            INIT: begin
                load = 1'b1;
                if (init_cnt == INIT_LAST) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                run_en = 1'b1;
            end
            default: state_nxt = INIT;
        endcase
    end

    assign ab_p0 = {fa, fb};
    assign {step_up, step_down, step_ill} = step_dir(ab_p1, ab_p0);
    assign up_p0   = run_en & step_up;
    assign down_p0 = run_en & step_down;
    assign ill_p0  = run_en & step_ill;

    // Decode stage: strobes and error bookkeeping registered one cycle after the filtered change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ab_p1     <= 2'b00;
            up        <= 1'b0;
            down      <= 1'b0;
            dir       <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            ab_p1 <= ab_p0;
            up    <= up_p0;
            down  <= down_p0;
            if (up_p0) begin
                dir <= 1'b1;
            end else if (down_p0) begin
                dir <= 1'b0;
            end
            // A jump landing on the clear cycle still counts as the first new error.
            if (clr_err) begin
                err       <= ill_p0;
                err_count <= ill_p0 ? ERR_W'(1) : '0;
            end else if (ill_p0) begin
                err       <= 1'b1;
                err_count <= sat_inc(err_count);
            end
        end
    end

endmodule
